// File: rtl/nn_pool_pkg.sv
// -----------------------------------------------------------------------------
// nn_pool_pkg
// Shared definitions for the pooling stage:
//   DATA_W_DEF  - default pixel width of the adder/ReLU sums
//   POOL_STRIDE - window size and stride of the 2x2 max-pool
//   SMAX_W      - working width of smax(); callers sign-extend into it
//   smax()      - signed maximum, ties return the first argument
// -----------------------------------------------------------------------------
package nn_pool_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int POOL_STRIDE = 2;
  localparam int SMAX_W      = 32;

  // Signed max; 'a' wins a tie so the earlier pixel of a pair is kept.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    if (b > a) begin
      return b;
    end else begin
      return a;
    end
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// Register-array line buffer holding the horizontal pair-max of the last
// even row, one entry per pooling window. Contents are not reset; every entry
// is rewritten by an even row before an odd row reads it.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address (window index)
//   wdata_i  write data
//   raddr_i  read address (window index)
//   rdata_o  combinational read data, so an odd row sees no read bubble
// -----------------------------------------------------------------------------
module pool_line_buf
  import nn_pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
)(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Single write port; storage intentionally has no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/sum_maxpool_2x2.sv
// -----------------------------------------------------------------------------
// sum_maxpool_2x2
// Streaming 2x2 / stride-2 signed max-pool between the adder stage and the
// feature-map writeback. Pixels arrive in raster order, one per accepted beat.
// Even rows store their horizontal pair-max in a line buffer; odd rows combine
// their pair-max with the stored value and emit one pooled pixel per window,
// one cycle after the odd-row odd-column beat.
//
// Optional feature macro: POOL_BYPASS_EN
//   When defined, bypass_i exists; bypass_i=1 forwards every accepted beat to
//   the output with one cycle of latency (counters still advance). bypass_i
//   may only change between frames.
//
// Ports:
//   clk_i          clock, all logic on posedge
//   rst_i          asynchronous active-high reset
//   data_i         input pixel (two's complement)
//   valid_i        data_i valid
//   frame_start_i  marks data_i as row 0 / col 0 of a new frame
//   ready_o        a beat can be accepted this cycle
//   data_o         pooled pixel (registered)
//   valid_o        data_o valid (registered)
//   bypass_i       pass-through mode (POOL_BYPASS_EN only)
//   ready_i        downstream accepts data_o
// -----------------------------------------------------------------------------
module sum_maxpool_2x2
  import nn_pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 32
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              frame_start_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
`ifdef POOL_BYPASS_EN
  input  logic              bypass_i,
`endif
  input  logic              ready_i
);

  localparam int NUM_WIN = IMG_W / POOL_STRIDE;
  // A one-entry buffer still needs a 1-bit address port.
  localparam int ADDR_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int COL_W   = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 32'sd1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(32'sd1);

  if ((IMG_W < POOL_STRIDE) || ((IMG_W % POOL_STRIDE) != 32'sd0)) begin : g_bad_img_w
    $error("sum_maxpool_2x2: IMG_W must be even and >= 2");
  end
  if ((DATA_W < 2) || (DATA_W > SMAX_W)) begin : g_bad_data_w
    $error("sum_maxpool_2x2: DATA_W out of supported range");
  end

  // Registered state
  logic [COL_W-1:0]  r_col_cnt;
  logic              r_row_odd;
  logic [DATA_W-1:0] r_h_hold;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Combinational datapath
  logic              w_accept;
  logic [COL_W-1:0]  w_col;
  logic              w_row_odd;
  logic              w_col_odd;
  logic [ADDR_W-1:0] w_laddr;
  logic [DATA_W-1:0] w_lbuf_rd;
  logic [DATA_W-1:0] w_hmax;
  logic [DATA_W-1:0] w_pool;
  logic              w_lbuf_we;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic [COL_W-1:0]  w_col_nxt;
  logic              w_row_odd_nxt;
  logic              w_bypass;

`ifdef POOL_BYPASS_EN
  assign w_bypass = bypass_i;
`else
  assign w_bypass = 1'b0;
`endif

  // A new result can only load when the output slot is free or draining,
  // which also keeps data_o stable while stalled.
  assign ready_o  = ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o;

  // frame_start_i overrides the counters for the beat it qualifies.
  assign w_col     = frame_start_i ? {COL_W{1'b0}} : r_col_cnt;
  assign w_row_odd = frame_start_i ? 1'b0 : r_row_odd;
  assign w_col_odd = w_col[0];
  assign w_laddr   = ADDR_W'(w_col >> 1'b1);

  // Horizontal pair-max (ties keep the held even-column pixel), then the
  // vertical max against the stored even-row pair-max. No widening.
  assign w_hmax = DATA_W'(smax(SMAX_W'($signed(r_h_hold)), SMAX_W'($signed(data_i))));
  assign w_pool = DATA_W'(smax(SMAX_W'($signed(w_lbuf_rd)), SMAX_W'($signed(w_hmax))));

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_WIN),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (w_lbuf_we),
    .waddr_i (w_laddr),
    .wdata_i (w_hmax),
    .raddr_i (w_laddr),
    .rdata_o (w_lbuf_rd)
  );

  // Next-state decode for counters, line-buffer write and output load.
  always_comb begin
    w_col_nxt     = r_col_cnt;
    w_row_odd_nxt = r_row_odd;
    w_lbuf_we     = 1'b0;
    w_load        = 1'b0;
    w_load_data   = w_pool;
    if (w_accept) begin
      if (w_col == COL_LAST) begin
        w_col_nxt     = {COL_W{1'b0}};
        w_row_odd_nxt = ~w_row_odd;
      end else begin
        w_col_nxt     = w_col + COL_ONE;
        w_row_odd_nxt = w_row_odd;
      end
      w_lbuf_we = w_col_odd & ~w_row_odd;
      if (w_bypass) begin
        w_load      = 1'b1;
        w_load_data = data_i;
      end else begin
        w_load      = w_col_odd & w_row_odd;
        w_load_data = w_pool;
      end
    end else begin
      w_lbuf_we = 1'b0;
      w_load    = 1'b0;
    end
  end

  // Column/row counters and the even-column hold register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col_cnt <= {COL_W{1'b0}};
      r_row_odd <= 1'b0;
      r_h_hold  <= {DATA_W{1'b0}};
    end else begin
      r_col_cnt <= w_col_nxt;
      r_row_odd <= w_row_odd_nxt;
      if (w_accept && !w_col_odd) begin
        r_h_hold <= data_i;
      end
    end
  end

  // Output register: a new result wins over clearing on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= {DATA_W{1'b0}};
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_load_data;
      r_valid <= 1'b1;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;

endmodule
